// File: rtl/alu_cmd_pkg.sv
// ---------------------------------------------------------------------------
// alu_cmd_pkg
// Shared definitions for the ALU command sequencer and its reference model:
//   - ALU op encodings
//   - sequencer state type
//   - default operand width
// ---------------------------------------------------------------------------
package alu_cmd_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_ABSDIFF = 2'b01;
    localparam logic [1:0] OP_SUB     = 2'b10;
    localparam logic [1:0] OP_ADD_ALT = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// ---------------------------------------------------------------------------
// alu_ref_model
// Purely combinational reference for the external gate-level ALU. Used by the
// sequencer's optional result checker (ALU_CMD_SEQUENCER_CHECK_EN).
//
// Ports:
//   a_i, b_i     operands (WIDTH)
//   op_i         00 A+B, 01 |A-B|, 10 A-B, 11 A+B
//   result_o     result (WIDTH), mod 2^WIDTH
//   zero_o       raw sum/difference is zero (before magnitude)
//   overflow_o   carry into MSB XOR carry out of the add/sub stage
// ---------------------------------------------------------------------------
module alu_ref_model
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);

    logic             sub_en;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;
    logic             carry_msb;

    always_comb begin
        sub_en    = (op_i == OP_SUB) || (op_i == OP_ABSDIFF);
        // Subtraction as A + ~B + 1, matching the ALU's single adder stage.
        b_eff     = sub_en ? ~b_i : b_i;
        sum       = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_en};
        raw       = sum[WIDTH-1:0];
        carry_msb = a_i[WIDTH-1] ^ b_eff[WIDTH-1] ^ raw[WIDTH-1];
        overflow_o = carry_msb ^ sum[WIDTH];
        zero_o     = (raw == {WIDTH{1'b0}});
        // Magnitude of the most negative difference wraps back to itself.
        if ((op_i == OP_ABSDIFF) && raw[WIDTH-1]) begin
            result_o = ~raw + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result_o = raw;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Drives a gate-level ALU from registered operands, waits SETTLE_CYCLES for
// the gates to settle, then captures result/flags into a response channel.
// A WIDTH-bit accumulator holds the last captured result so commands can be
// chained without external readback.
//
// Optional build macro ALU_CMD_SEQUENCER_CHECK_EN: instantiates alu_ref_model
// and sets the sticky chk_err flag whenever the captured ALU outputs disagree
// with it. Without the macro chk_err is tied low. Port list is identical.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_a, cmd_b, cmd_op, cmd_use_acc command payload
//   alu_a, alu_b, alu_op             registered drive to the ALU
//   alu_result, alu_zero, alu_overflow ALU outputs
//   rsp_valid/rsp_ready              response handshake
//   rsp_result, rsp_zero, rsp_overflow captured response
//   acc                              accumulator
//   chk_err                          sticky reference mismatch flag
//
// State | meaning
// IDLE   | ready for a command; ALU drive holds the previous command
// SETTLE | ALU driven, counting down the settle interval
// RESP   | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_cmd_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_use_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [WIDTH-1:0] acc,
    output logic             chk_err
);

    localparam int         CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            acc_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_ovf_q    <= rsp_ovf_d;
            acc_q        <= acc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_ovf_d    = rsp_ovf_q;
        acc_d        = acc_q;
        capture      = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_a_d  = cmd_use_acc ? acc_q : cmd_a;
                    alu_b_d  = cmd_b;
                    alu_op_d = cmd_op;
                    cnt_d    = CNT_INIT;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    capture      = 1'b1;
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_ovf_d    = alu_overflow;
                    acc_d        = alu_result;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate with rst_n so the channel reads not-ready while reset is held.
    assign cmd_ready    = rst_n && (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_overflow = rsp_ovf_q;
    assign acc          = acc_q;

`ifdef ALU_CMD_SEQUENCER_CHECK_EN
    logic [WIDTH-1:0] ref_result;
    logic             ref_zero;
    logic             ref_ovf;
    logic             chk_err_q, chk_err_d;

    alu_ref_model #(.WIDTH(WIDTH)) u_ref (
        .a_i        (alu_a_q),
        .b_i        (alu_b_q),
        .op_i       (alu_op_q),
        .result_o   (ref_result),
        .zero_o     (ref_zero),
        .overflow_o (ref_ovf)
    );

    always_comb begin
        chk_err_d = chk_err_q;
        if (capture &&
            ({alu_result, alu_zero, alu_overflow} != {ref_result, ref_zero, ref_ovf})) begin
            chk_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator/driver for the 4-bit gate-level ALU (add, absolute difference, subtract).
- Accepts operation commands over a valid/ready channel and drives the ALU operand and op lines from registers.
- Waits a programmable settle interval to cover gate delays, then captures result and flags into a response channel.
- Keeps a 4-bit accumulator so chained operations need no external readback.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- SETTLE_CYCLES, 4, clock cycles between driving the ALU and sampling it; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_a  input  WIDTH  operand A; ignored when cmd_use_acc=1.
- cmd_b  input  WIDTH  operand B.
- cmd_op  input  2  00 A+B, 01 |A-B|, 10 A-B, 11 A+B.
- cmd_use_acc  input  1  use accumulator as operand A.
- alu_a  output  WIDTH  registered operand A to ALU.
- alu_b  output  WIDTH  registered operand B to ALU.
- alu_op  output  2  registered op to ALU.
- alu_result  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_overflow  input  1  ALU overflow flag.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  WIDTH  captured result.
- rsp_zero  output  1  captured zero flag.
- rsp_overflow  output  1  captured overflow flag.
- acc  output  WIDTH  accumulator value.
- chk_err  output  1  sticky mismatch flag; see Optional Feature.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. alu_a/alu_b/alu_op/rsp_* /acc/chk_err=0. Settle counter=0. cmd_ready=0 while rst_n=0.
- Reset mid-operation aborts the in-flight command with no response.
- Three states: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: alu_a<=(cmd_use_acc?acc:cmd_a), alu_b<=cmd_b, alu_op<=cmd_op, cnt<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - cmd_ready=0. ALU drive registers are held stable.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_overflow<=alu_overflow, acc<=alu_result, go to RESP.
- RESP:
  - rsp_valid=1, cmd_ready=0. Response outputs are held stable until rsp_valid&&rsp_ready.
  - On rsp_valid&&rsp_ready: go to IDLE.
  - rsp_valid rises exactly SETTLE_CYCLES cycles after the accept edge.
- No bypass: cmd_ready is low during RESP even when rsp_ready=1. Back-to-back throughput is one command per SETTLE_CYCLES+2 cycles.
- alu_* keep the last command's values while idle; no return to zero.
- Arithmetic is mod 2^WIDTH.
- Overflow definition: carry into MSB XOR carry out of the add/sub stage.
- Zero is asserted when the raw sum/difference is 0.
- |A-B| is the two's-complement magnitude of the WIDTH-bit difference. Difference 1000 yields 1000.
- acc is updated on every captured response, whatever cmd_use_acc was.

Optional Feature:
- Macro: ALU_CMD_SEQUENCER_CHECK_EN.
- Defined:
  - An internal reference model computes the expected {result, zero, overflow} from alu_a/alu_b/alu_op.
  - At the capture edge, any mismatch sets chk_err=1.
  - chk_err stays set until rst_n=0.
- Undefined: no model is instantiated and chk_err is tied 0.
- The port list is identical in both builds.

Decomposition:
- Package alu_cmd_pkg:
  - op constants OP_ADD=2'b00, OP_ABSDIFF=2'b01, OP_SUB=2'b10, OP_ADD_ALT=2'b11.
  - state enum IDLE/SETTLE/RESP.
  - default WIDTH.
- One combinational sub-module, alu_ref_model (A, B, op -> result, zero, overflow), instantiated only under the macro.

Test Plan:
- Reset then cmd A=3, B=5, op=00 -> rsp_valid SETTLE_CYCLES cycles after accept; result=8, overflow=1, zero=0; acc=8.
- A=2, B=7, op=01 -> result=5, overflow=0, zero=0.
- A=5, B=5, op=10 -> result=0, zero=1, overflow=0.
- A=0, B=8, op=01 -> result=8, overflow=1.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp_* stable, cmd_ready=0, a new cmd_valid is not accepted; the next command is taken only after the handshake.
- Accumulator: after reset, two cmds cmd_use_acc=1, B=3, op=00 -> results 3 then 6; alu_a=3 on the second command.
- Reset asserted in SETTLE -> outputs zeroed immediately, no rsp_valid.
- With the macro defined, force alu_result to 4'hF on an A=1, B=1, op=00 command -> chk_err=1 and stays set.
